kid_motion: RTL and testbench
=============================

// Module: kid_motion
// PURPOSE
//  Player-character engine. Decodes PS/2 make/break bytes into held-key flags.
//  Runs run/jump/fall physics once per frame tick, tracks position and facing,
//  and produces per-pixel sprite lookup coordinates plus a transparency-keyed
//  pixel for the VGA compositor. Sits between the PS/2 receiver and the
//  sprite ROM / pixel mux.
// PARAMETERS
//  INIT_X     60      reset x (left column of hitbox)
//  INIT_Y     558     reset y (top row of hitbox)
//  SPR_W      26      hitbox width, px
//  SPR_H      23      hitbox height, px
//  GROUND_Y   581     first row below floor; grounded when kid_y==GROUND_Y-SPR_H
//  X_MIN      0       left bound
//  X_MAX      800     right bound (exclusive); kid_x <= X_MAX-SPR_W
//  RUN_SPD    3       px/tick horizontal
//  JUMP_V     8       initial upward speed, px/tick
//  GRAV       1       vy increment per tick
//  VMAX       9       max downward speed
//  TRANSP     12'hF0F ROM colour treated as transparent
// PORTS
//  clk          in  1   system clock
//  rst          in  1   async active-high reset
//  update_en    in  1   1-cycle physics tick (once per frame)
//  toggle_en    in  1   1-cycle animation tick
//  key_valid    in  1   keycode strobe
//  keycode      in  8   PS/2 set-2 byte
//  col, row     in  10  current VGA pixel
//  rom_rgb      in  12  sprite ROM data for spr_sel/spr_frame/spr_col/spr_row
//  is_kid       out 1   pixel belongs to kid and is not TRANSP
//  kid_rgb      out 12  rom_rgb when is_kid, else 0
//  kid_x, kid_y out 10  hitbox top-left
//  facing_left  out 1   sprite mirror flag
//  spr_sel      out 2   0 stand/run, 1 jump, 2 fall
//  spr_frame    out 2   animation frame
//  spr_col      out 5   sprite-local column (mirrored when facing_left)
//  spr_row      out 5   sprite-local row
// BEHAVIOUR
//  Reset: kid_x=INIT_X, kid_y=INIT_Y, vy=0, state STAND, facing right,
//   frame 0, all key flags 0, is_kid/kid_rgb 0.
//  Keys: 8'hE0 ignored; 8'hF0 arms break, next byte clears its flag. Any other
//   byte sets its flag: 6B left, 74 right, 12 jump. Unknown codes clear armed
//   break. Jump make while jump flag=0 sets jump_req.
//  States: STAND, RUN, JUMP (airborne, vy<0), FALL (airborne, vy>=0).
//  Each update_en, using flags from the previous edge:
//   - Horizontal: left XOR right moves RUN_SPD, sets facing; clamp to
//     [X_MIN, X_MAX-SPR_W]. Both or neither held gives no motion.
//   - Jump: jump_req while grounded gives vy=-JUMP_V, JUMP. jump_req is
//     cleared every tick, so there is no buffering.
//   - Variable height: jump flag released while in JUMP gives vy=vy>>>1
//     (arithmetic shift), once.
//   - Airborne: y+=vy, then vy=min(vy+GRAV,VMAX); vy>=0 selects FALL.
//     Landing when y+vy>=GROUND_Y-SPR_H: snap y, vy=0, STAND or RUN.
//     Ceiling when y+vy<0: y=0, vy=0, FALL.
//   - Walking off is not possible (flat floor); grounded is STAND/RUN by input.
//  vy is signed 6-bit. Position math uses 11-bit signed intermediates, no wrap.
//  key_valid coincident with update_en: flag updates land this edge, physics
//   sees the old flags.
//  toggle_en: spr_frame+1 mod 4 in RUN; held at 0 in STAND. JUMP/FALL use
//   frames 0-1 alternating.
//  Draw window: width 26/18/27, height 23/23/20 for sel 0/1/2, bottom-aligned
//   to kid_y+SPR_H and left-aligned to kid_x. spr_*, is_kid and kid_rgb are
//   combinational from col/row and registered state (ROM is async-read).
//  Reset mid-air or mid-break-sequence restores reset values at once.
// CONFIGURATION
//  KID_DOUBLE_JUMP_EN defined: one extra jump_req honoured while airborne
//   (vy=-(JUMP_V-1), JUMP). The extra jump re-arms on landing.
//  Undefined: airborne jump_req is discarded.
// STRUCTURE
//  kid_pkg: state encoding, key codes (6B/74/12/E0/F0), per-state sprite W/H.
//  Sub-module kid_key_decoder: make/break FSM producing held flags and
//   jump_req.
//  Top holds physics FSM, animation counter and draw-window logic.
// TESTING
//  1 Reset, idle 10 ticks: x=60, y=558, STAND, is_kid=0 at col=0,row=0.
//  2 74 make, 5 ticks, F0 74: x=75, RUN then STAND, facing_left=0.
//  3 12 make on ground, hold: y rises to 558-36=522 after 8 ticks, lands
//    at 558 after 17 ticks.
//  4 12 make, F0 12 after 2 ticks: vy -6 becomes -3, apex below test 3.
//  5 6B held from x=60 for 30 ticks: x clamps at 0. Pixel with
//    rom_rgb=F0F gives is_kid=0.
//  6 KID_DOUBLE_JUMP_EN, second 12 make at apex: vy=-7. A third is ignored.

Source files
------------

// File: rtl/kid_pkg.sv
// Shared encodings for the kid player engine: FSM states, PS/2 set-2 codes,
// and per-pose sprite draw-window sizes.
package kid_pkg;

  typedef enum logic [1:0] {ST_STAND, ST_RUN, ST_JUMP, ST_FALL} kid_state_t;
  typedef enum logic {KD_MAKE, KD_BREAK} kd_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_JUMP  = 8'h12;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_BRK   = 8'hF0;

  function automatic logic [4:0] sel_w(input logic [1:0] sel);
    case (sel)
      2'd1:    sel_w = 5'd18;
      2'd2:    sel_w = 5'd27;
      default: sel_w = 5'd26;
    endcase
  endfunction

  function automatic logic [4:0] sel_h(input logic [1:0] sel);
    case (sel)
      2'd2:    sel_h = 5'd20;
      default: sel_h = 5'd23;
    endcase
  endfunction

endpackage

// File: rtl/kid_key_decoder.sv
// PS/2 make/break decoder: keeps held flags for left/right/jump and raises a
// one-shot jump request that lives until the next physics tick.
module kid_key_decoder
  import kid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       update_en,
  input  logic       key_valid,
  input  logic [7:0] keycode,
  output logic       left_held,
  output logic       right_held,
  output logic       jump_held,
  output logic       jump_req
);

  kd_state_t kd_state, kd_state_n;
  logic      left_n, right_n, jump_n, req_n, is_make;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kd_state   <= KD_MAKE;
      left_held  <= 1'b0;
      right_held <= 1'b0;
      jump_held  <= 1'b0;
      jump_req   <= 1'b0;
    end else begin
      kd_state   <= kd_state_n;
      left_held  <= left_n;
      right_held <= right_n;
      jump_held  <= jump_n;
      jump_req   <= req_n;
    end
  end

  // A make arriving on a tick edge survives the clear: physics has not seen it yet.
  always_comb begin
    kd_state_n = kd_state;
    left_n     = left_held;
    right_n    = right_held;
    jump_n     = jump_held;
    req_n      = update_en ? 1'b0 : jump_req;
    is_make    = (kd_state == KD_MAKE);
    if (key_valid && keycode != KEY_EXT) begin
      if (keycode == KEY_BRK) begin
        kd_state_n = KD_BREAK;
      end else begin
        kd_state_n = KD_MAKE;
        case (keycode)
          KEY_LEFT:  left_n  = is_make;
          KEY_RIGHT: right_n = is_make;
          KEY_JUMP: begin
            jump_n = is_make;
            if (is_make && !jump_held) req_n = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/kid_motion.sv
// Player-character engine: key decode, per-frame run/jump/fall physics,
// animation frame and sprite draw window. Optional KID_DOUBLE_JUMP_EN.
module kid_motion
  import kid_pkg::*;
#(
  parameter int          INIT_X   = 60,
  parameter int          INIT_Y   = 558,
  parameter int          SPR_W    = 26,
  parameter int          SPR_H    = 23,
  parameter int          GROUND_Y = 581,
  parameter int          X_MIN    = 0,
  parameter int          X_MAX    = 800,
  parameter int          RUN_SPD  = 3,
  parameter int          JUMP_V   = 8,
  parameter int          GRAV     = 1,
  parameter int          VMAX     = 9,
  parameter logic [11:0] TRANSP   = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update_en,
  input  logic        toggle_en,
  input  logic        key_valid,
  input  logic [7:0]  keycode,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic [11:0] rom_rgb,
  output logic        is_kid,
  output logic [11:0] kid_rgb,
  output logic [9:0]  kid_x,
  output logic [9:0]  kid_y,
  output logic        facing_left,
  output logic [1:0]  spr_sel,
  output logic [1:0]  spr_frame,
  output logic [4:0]  spr_col,
  output logic [4:0]  spr_row
);

  localparam logic signed [10:0] X_LO    = 11'(X_MIN);
  localparam logic signed [10:0] X_HI    = 11'(X_MAX - SPR_W);
  localparam logic signed [10:0] GND_TOP = 11'(GROUND_Y - SPR_H);
  localparam logic signed [10:0] RUN_S   = 11'(RUN_SPD);
  localparam logic signed [10:0] GRAV_S  = 11'(GRAV);
  localparam logic signed [10:0] V_MAX   = 11'(VMAX);
  localparam logic signed [10:0] V_JUMP  = 11'(-JUMP_V);
  localparam logic signed [10:0] V_DJ    = 11'(1 - JUMP_V);

  logic left_held, right_held, jump_held, jump_req;

  kid_key_decoder u_keys (
    .clk        (clk),
    .rst        (rst),
    .update_en  (update_en),
    .key_valid  (key_valid),
    .keycode    (keycode),
    .left_held  (left_held),
    .right_held (right_held),
    .jump_held  (jump_held),
    .jump_req   (jump_req)
  );

  kid_state_t        state, state_n;
  logic signed [5:0] vy;
  logic              cut_done, extra_used;
  logic              cut_n, extra_n, facing_n, moving, dj_ok;
  logic signed [10:0] x_s, y_s, vy_s, x_n, y_n, vy_n, vy_e, y_t, vy_t;

`ifdef KID_DOUBLE_JUMP_EN
  assign dj_ok = jump_req && !extra_used;
`else
  assign dj_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_STAND;
      kid_x       <= 10'(INIT_X);
      kid_y       <= 10'(INIT_Y);
      vy          <= '0;
      facing_left <= 1'b0;
      cut_done    <= 1'b0;
      extra_used  <= 1'b0;
      spr_frame   <= '0;
    end else begin
      if (update_en) begin
        state       <= state_n;
        kid_x       <= x_n[9:0];
        kid_y       <= y_n[9:0];
        vy          <= vy_n[5:0];
        facing_left <= facing_n;
        cut_done    <= cut_n;
        extra_used  <= extra_n;
      end
      if (state == ST_STAND)
        spr_frame <= '0;
      else if (toggle_en)
        spr_frame <= (state == ST_RUN) ? spr_frame + 2'd1 : {1'b0, ~spr_frame[0]};
    end
  end

  always_comb begin
    x_s      = signed'({1'b0, kid_x});
    y_s      = signed'({1'b0, kid_y});
    vy_s     = {{5{vy[5]}}, vy};
    moving   = left_held ^ right_held;
    state_n  = state;
    x_n      = x_s;
    y_n      = y_s;
    vy_n     = vy_s;
    vy_e     = vy_s;
    y_t      = '0;
    vy_t     = '0;
    facing_n = facing_left;
    cut_n    = cut_done;
    extra_n  = extra_used;

    if (moving && right_held) begin
      facing_n = 1'b0;
      x_n      = (x_s + RUN_S > X_HI) ? X_HI : x_s + RUN_S;
    end else if (moving) begin
      facing_n = 1'b1;
      x_n      = (x_s - RUN_S < X_LO) ? X_LO : x_s - RUN_S;
    end

    case (state)
      ST_STAND, ST_RUN: begin
        if (jump_req) begin
          vy_n    = V_JUMP;
          state_n = ST_JUMP;
          cut_n   = 1'b0;
        end else begin
          state_n = moving ? ST_RUN : ST_STAND;
        end
      end
      default: begin
        if (dj_ok) begin
          vy_n    = V_DJ;
          state_n = ST_JUMP;
          cut_n   = 1'b0;
          extra_n = 1'b1;
        end else begin
          // Early release halves the rise once; the halved speed is used this tick.
          if (state == ST_JUMP && !jump_held && !cut_done) begin
            vy_e  = vy_s >>> 1;
            cut_n = 1'b1;
          end
          y_t = y_s + vy_e;
          if (y_t >= GND_TOP) begin
            y_n     = GND_TOP;
            vy_n    = '0;
            state_n = moving ? ST_RUN : ST_STAND;
            extra_n = 1'b0;
          end else if (y_t < 11'sd0) begin
            y_n     = '0;
            vy_n    = '0;
            state_n = ST_FALL;
          end else begin
            y_n     = y_t;
            vy_t    = vy_e + GRAV_S;
            vy_n    = (vy_t > V_MAX) ? V_MAX : vy_t;
            state_n = (vy_n < 11'sd0) ? ST_JUMP : ST_FALL;
          end
        end
      end
    endcase
  end

  logic [4:0]  win_w, win_h, loc_col;
  logic [10:0] x_l, x_r, y_b, y_top;
  logic        in_win;

  always_comb begin
    case (state)
      ST_JUMP: spr_sel = 2'd1;
      ST_FALL: spr_sel = 2'd2;
      default: spr_sel = 2'd0;
    endcase
    win_w   = sel_w(spr_sel);
    win_h   = sel_h(spr_sel);
    x_l     = {1'b0, kid_x};
    x_r     = x_l + 11'(win_w);
    y_b     = {1'b0, kid_y} + 11'(SPR_H);
    y_top   = y_b - 11'(win_h);
    in_win  = ({1'b0, col} >= x_l) && ({1'b0, col} < x_r) &&
              ({1'b0, row} >= y_top) && ({1'b0, row} < y_b);
    loc_col = 5'(col - kid_x);
    spr_col = facing_left ? 5'(win_w - 5'd1 - loc_col) : loc_col;
    spr_row = 5'(row - y_top);
    is_kid  = in_win && (rom_rgb != TRANSP);
    kid_rgb = is_kid ? rom_rgb : '0;
  end

endmodule

// File: tb/tb_kid_motion.sv
// Self-checking bench for kid_motion: scoreboarded position/pose checks after
// tick sequences plus table-driven draw-window pixel vectors.
module tb_kid_motion;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update_en = 1'b0, toggle_en = 1'b0, key_valid = 1'b0;
  logic [7:0]  keycode = '0;
  logic [9:0]  col = '0, row = '0;
  logic [11:0] rom_rgb = '0;
  logic        is_kid, facing_left;
  logic [11:0] kid_rgb;
  logic [9:0]  kid_x, kid_y;
  logic [1:0]  spr_sel, spr_frame;
  logic [4:0]  spr_col, spr_row;

  int passed = 0;
  int total  = 0;

  kid_motion dut (
    .clk(clk), .rst(rst), .update_en(update_en), .toggle_en(toggle_en),
    .key_valid(key_valid), .keycode(keycode), .col(col), .row(row),
    .rom_rgb(rom_rgb), .is_kid(is_kid), .kid_rgb(kid_rgb), .kid_x(kid_x),
    .kid_y(kid_y), .facing_left(facing_left), .spr_sel(spr_sel),
    .spr_frame(spr_frame), .spr_col(spr_col), .spr_row(spr_row)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {string tag; int x; int y; int sel; int fl;} pos_t;
  typedef struct {int c; int r; logic [11:0] rgb; bit k; bit spr; int scol; int srow;} pix_t;

  pos_t sb[$];
  pix_t pv_reset[$], pv_fall[$], pv_left[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) update_en = 1'b1;
      @(negedge clk) update_en = 1'b0;
    end
  endtask

  task automatic toggles(input int n);
    repeat (n) begin
      @(negedge clk) toggle_en = 1'b1;
      @(negedge clk) toggle_en = 1'b0;
    end
  endtask

  task automatic key(input logic [7:0] b);
    @(negedge clk) begin key_valid = 1'b1; keycode = b; end
    @(negedge clk) key_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic check_pos();
    pos_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".x"}, int'(kid_x), e.x);
    chk({e.tag, ".y"}, int'(kid_y), e.y);
    chk({e.tag, ".sel"}, int'(spr_sel), e.sel);
    chk({e.tag, ".facing"}, int'(facing_left), e.fl);
  endtask

  task automatic step(input int n, input string tag, input int x, input int y,
                      input int sel, input int fl);
    sb.push_back(pos_t'{tag, x, y, sel, fl});
    ticks(n);
    check_pos();
  endtask

  task automatic run_pix(input string tag, input pix_t q[$]);
    foreach (q[i]) begin
      col = 10'(q[i].c); row = 10'(q[i].r); rom_rgb = q[i].rgb;
      #1;
      chk($sformatf("%s[%0d].is_kid", tag, i), int'(is_kid), int'(q[i].k));
      chk($sformatf("%s[%0d].rgb", tag, i), int'(kid_rgb), q[i].k ? int'(q[i].rgb) : 0);
      if (q[i].spr) begin
        chk($sformatf("%s[%0d].scol", tag, i), int'(spr_col), q[i].scol);
        chk($sformatf("%s[%0d].srow", tag, i), int'(spr_row), q[i].srow);
      end
    end
  endtask

  initial begin
    // stand pose at (60,558): cols 60..85, rows 558..580
    pv_reset.push_back(pix_t'{0,   0,   12'hF00, 1'b0, 1'b0, 0,  0});
    pv_reset.push_back(pix_t'{60,  558, 12'h123, 1'b1, 1'b1, 0,  0});
    pv_reset.push_back(pix_t'{85,  580, 12'hABC, 1'b1, 1'b1, 25, 22});
    pv_reset.push_back(pix_t'{86,  580, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_reset.push_back(pix_t'{59,  570, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_reset.push_back(pix_t'{70,  557, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_reset.push_back(pix_t'{70,  581, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_reset.push_back(pix_t'{70,  570, 12'hF0F, 1'b0, 1'b1, 10, 12});
    // fall pose at (75,522): 27x20 bottom-aligned, cols 75..101, rows 525..544
    pv_fall.push_back(pix_t'{75,  525, 12'hABC, 1'b1, 1'b1, 0,  0});
    pv_fall.push_back(pix_t'{101, 544, 12'h123, 1'b1, 1'b1, 26, 19});
    pv_fall.push_back(pix_t'{102, 530, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_fall.push_back(pix_t'{80,  524, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_fall.push_back(pix_t'{80,  545, 12'hABC, 1'b0, 1'b0, 0,  0});
    // stand pose at (0,558) facing left: columns mirrored
    pv_left.push_back(pix_t'{0,   570, 12'hABC, 1'b1, 1'b1, 25, 12});
    pv_left.push_back(pix_t'{25,  570, 12'hABC, 1'b1, 1'b1, 0,  12});
    pv_left.push_back(pix_t'{26,  570, 12'hABC, 1'b0, 1'b0, 0,  0});
    pv_left.push_back(pix_t'{10,  570, 12'hF0F, 1'b0, 1'b1, 15, 12});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.push_back(pos_t'{"reset", 60, 558, 0, 0});
    check_pos();
    chk("reset.frame", int'(spr_frame), 0);
    run_pix("reset_pix", pv_reset);

    // idle
    toggles(2);
    step(10, "idle", 60, 558, 0, 0);
    chk("idle.frame", int'(spr_frame), 0);

    // run right then stop
    key(8'h74);
    step(5, "run5", 75, 558, 0, 0);
    toggles(3);
    chk("run.frame", int'(spr_frame), 3);
    key(8'hF0); key(8'h74);
    step(1, "stop", 75, 558, 0, 0);
    @(negedge clk);
    chk("stop.frame", int'(spr_frame), 0);
    step(2, "still", 75, 558, 0, 0);

    // full jump, held
    key(8'h12);
    step(1, "jump0", 75, 558, 1, 0);
    step(8, "apex", 75, 522, 2, 0);
    run_pix("fall_pix", pv_fall);
    step(8, "desc16", 75, 550, 2, 0);
    step(1, "land", 75, 558, 0, 0);
    key(8'hF0); key(8'h12);

    // short hop: release after two airborne ticks halves vy -6 -> -3
    key(8'h12);
    step(1, "hop0", 75, 558, 1, 0);
    step(2, "hop2", 75, 543, 1, 0);
    key(8'hF0); key(8'h12);
    step(1, "hop_cut", 75, 540, 1, 0);
    step(2, "hop_apex", 75, 537, 2, 0);
    step(7, "hop_land", 75, 558, 0, 0);

    // reset in the middle of a break sequence
    key(8'hF0);
    pulse_reset();
    sb.push_back(pos_t'{"rst_brk", 60, 558, 0, 0});
    check_pos();
    key(8'h74);
    step(1, "rst_make", 63, 558, 0, 0);
    key(8'hF0); key(8'h74);

    // left clamp, mirroring, both keys, right clamp
    key(8'h6B);
    step(10, "left10", 33, 558, 0, 1);
    step(20, "left30", 0, 558, 0, 1);
    run_pix("left_pix", pv_left);
    key(8'h74);
    step(3, "both", 0, 558, 0, 1);
    key(8'hF0); key(8'h6B);
    step(260, "rclamp", 774, 558, 0, 0);
    key(8'hF0); key(8'h74);

    // reset mid-air
    key(8'h12);
    step(3, "air", 774, 543, 1, 0);
    pulse_reset();
    sb.push_back(pos_t'{"rst_air", 60, 558, 0, 0});
    check_pos();
    step(2, "post_rst", 60, 558, 0, 0);

    // airborne jump press: discarded, or one extra jump when enabled
    key(8'h12);
    step(1, "dj0", 60, 558, 1, 0);
    step(1, "dj1", 60, 550, 1, 0);
    key(8'hF0); key(8'h12);
    step(4, "dj5", 60, 540, 2, 0);
    key(8'h12);
`ifdef KID_DOUBLE_JUMP_EN
    step(1, "dj6", 60, 540, 1, 0);
    step(1, "dj7", 60, 533, 1, 0);
    step(6, "dj13", 60, 512, 2, 0);
    key(8'hF0); key(8'h12);
    key(8'h12);
    step(1, "dj14", 60, 512, 2, 0);
    step(1, "dj15", 60, 513, 2, 0);
`else
    step(1, "dj6", 60, 540, 2, 0);
    step(1, "dj7", 60, 541, 2, 0);
`endif
    toggles(3);
    chk("air.frame", int'(spr_frame), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
